// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the pipelined RISC-V core: ALU operation
// codes, layout of the packed decode control bundle, and the major opcodes
// that the control unit decodes.
package cpu_ctrl_pkg;

    // ALU operation selector produced by the control unit
    localparam logic [1:0] ALU_OP_ADD    = 2'b00;
    localparam logic [1:0] ALU_OP_SUB    = 2'b01;
    localparam logic [1:0] ALU_OP_R_TYPE = 2'b10;

    // Packed control bundle: {alu_op[1:0], reg_write, mem_read, mem_2_reg,
    //                         mem_write, alu_src, branch, jump}
    localparam int CTRL_W         = 9;
    localparam int CTRL_JUMP      = 0;
    localparam int CTRL_BRANCH    = 1;
    localparam int CTRL_ALU_SRC   = 2;
    localparam int CTRL_MEM_WRITE = 3;
    localparam int CTRL_MEM_2_REG = 4;
    localparam int CTRL_MEM_READ  = 5;
    localparam int CTRL_REG_WRITE = 6;
    localparam int CTRL_ALU_OP_LO = 7;
    localparam int CTRL_ALU_OP_HI = 8;

    // Major opcodes shared with the control unit
    localparam logic [6:0] OPC_R_TYPE = 7'b0110011;
    localparam logic [6:0] OPC_I_TYPE = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // Assemble the control bundle in the canonical bit order
    function automatic logic [CTRL_W-1:0] pack_ctrl(
        input logic [1:0] alu_op,
        input logic       reg_write,
        input logic       mem_read,
        input logic       mem_2_reg,
        input logic       mem_write,
        input logic       alu_src,
        input logic       branch,
        input logic       jump
    );
        return {alu_op, reg_write, mem_read, mem_2_reg, mem_write, alu_src, branch, jump};
    endfunction

    // 32-bit increment that sticks at all-ones instead of wrapping
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        logic [31:0] r;
        if (v == 32'hFFFF_FFFF) begin
            r = v;
        end else begin
            r = v + 32'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pipe_reg_en.sv
// Generic pipeline flop bank: asynchronous active-low reset, synchronous
// clear-to-zero (wins over enable), load enable, otherwise hold.
module pipe_reg_en #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // State register: reset > clear > load > hold
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            q <= {W{1'b0}};
        end else if (clr) begin
            q <= {W{1'b0}};
        end else if (en) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register. Captures the decode control bundle and operands
// and presents them to EX one cycle later, with stall (en=0) and bubble
// insertion (flush, or an invalid decode slot). A bubble zeroes valid and
// all control bits but leaves data untouched, so an invalid slot can never
// write architectural state.
// Optional build macro ID_EX_PERF_CNT_EN adds saturating bubble/stall
// counters on outputs bubble_cnt and stall_cnt.
module id_ex_pipe_reg
    import cpu_ctrl_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int REG_ADDR_W = 5,
    parameter int FUNCT_W    = 4
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  en,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [1:0]            id_alu_op,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_mem_2_reg,
    input  logic                  id_mem_write,
    input  logic                  id_alu_src,
    input  logic                  id_branch,
    input  logic                  id_jump,
    input  logic [DATA_W-1:0]     id_pc,
    input  logic [DATA_W-1:0]     id_rs1_data,
    input  logic [DATA_W-1:0]     id_rs2_data,
    input  logic [DATA_W-1:0]     id_imm,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [FUNCT_W-1:0]    id_funct,
    output logic                  ex_valid,
    output logic [1:0]            ex_alu_op,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  ex_mem_2_reg,
    output logic                  ex_mem_write,
    output logic                  ex_alu_src,
    output logic                  ex_branch,
    output logic                  ex_jump,
    output logic [DATA_W-1:0]     ex_pc,
    output logic [DATA_W-1:0]     ex_rs1_data,
    output logic [DATA_W-1:0]     ex_rs2_data,
    output logic [DATA_W-1:0]     ex_imm,
    output logic [REG_ADDR_W-1:0] ex_rs1,
    output logic [REG_ADDR_W-1:0] ex_rs2,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [FUNCT_W-1:0]    ex_funct
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]           bubble_cnt,
    output logic [31:0]           stall_cnt
`endif
);

    localparam int CV_W   = CTRL_W + 1;
    localparam int DATA_T = 4 * DATA_W + 3 * REG_ADDR_W + FUNCT_W;

    logic              bubble_s;
    logic              stall_s;
    logic              data_en_s;
    logic [CV_W-1:0]   ctrl_d_s;
    logic [CV_W-1:0]   ctrl_q_s;
    logic [DATA_T-1:0] data_d_s;
    logic [DATA_T-1:0] data_q_s;

    // A bubble is loaded on flush or when decode offers an invalid slot;
    // data must not advance while flushing so EX operands stay stable.
    assign bubble_s  = flush | (en & ~id_valid);
    assign stall_s   = ~flush & ~en;
    assign data_en_s = en & ~flush;

    assign ctrl_d_s = {id_valid,
                       pack_ctrl(id_alu_op, id_reg_write, id_mem_read, id_mem_2_reg,
                                 id_mem_write, id_alu_src, id_branch, id_jump)};

    assign data_d_s = {id_pc, id_rs1_data, id_rs2_data, id_imm,
                       id_rs1, id_rs2, id_rd, id_funct};

    pipe_reg_en #(.W(CV_W)) u_ctrl_reg (
        .clk    (clk),
        .arst_n (arst_n),
        .en     (en),
        .clr    (bubble_s),
        .d      (ctrl_d_s),
        .q      (ctrl_q_s)
    );

    pipe_reg_en #(.W(DATA_T)) u_data_reg (
        .clk    (clk),
        .arst_n (arst_n),
        .en     (data_en_s),
        .clr    (1'b0),
        .d      (data_d_s),
        .q      (data_q_s)
    );

    assign ex_valid     = ctrl_q_s[CTRL_W];
    assign ex_alu_op    = ctrl_q_s[CTRL_ALU_OP_HI:CTRL_ALU_OP_LO];
    assign ex_reg_write = ctrl_q_s[CTRL_REG_WRITE];
    assign ex_mem_read  = ctrl_q_s[CTRL_MEM_READ];
    assign ex_mem_2_reg = ctrl_q_s[CTRL_MEM_2_REG];
    assign ex_mem_write = ctrl_q_s[CTRL_MEM_WRITE];
    assign ex_alu_src   = ctrl_q_s[CTRL_ALU_SRC];
    assign ex_branch    = ctrl_q_s[CTRL_BRANCH];
    assign ex_jump      = ctrl_q_s[CTRL_JUMP];

    assign {ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
            ex_rs1, ex_rs2, ex_rd, ex_funct} = data_q_s;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt_r;
    logic [31:0] stall_cnt_r;

    // Saturating event counters for bubbles loaded and stall cycles
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            bubble_cnt_r <= 32'd0;
            stall_cnt_r  <= 32'd0;
        end else begin
            bubble_cnt_r <= bubble_s ? sat_inc32(bubble_cnt_r) : bubble_cnt_r;
            stall_cnt_r  <= stall_s  ? sat_inc32(stall_cnt_r)  : stall_cnt_r;
        end
    end

    assign bubble_cnt = bubble_cnt_r;
    assign stall_cnt  = stall_cnt_r;
`else
    logic unused_s;
    assign unused_s = stall_s;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed self-checking bench for id_ex_pipe_reg.
module tb_id_ex_pipe_reg;

    logic        clk;
    logic        arst_n;
    logic        en;
    logic        flush;
    logic        id_valid;
    logic [1:0]  id_alu_op;
    logic        id_reg_write, id_mem_read, id_mem_2_reg, id_mem_write;
    logic        id_alu_src, id_branch, id_jump;
    logic [63:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_funct;
    logic        ex_valid;
    logic [1:0]  ex_alu_op;
    logic        ex_reg_write, ex_mem_read, ex_mem_2_reg, ex_mem_write;
    logic        ex_alu_src, ex_branch, ex_jump;
    logic [63:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [3:0]  ex_funct;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt, stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    id_ex_pipe_reg dut (
        .clk(clk), .arst_n(arst_n), .en(en), .flush(flush), .id_valid(id_valid),
        .id_alu_op(id_alu_op), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_2_reg(id_mem_2_reg), .id_mem_write(id_mem_write), .id_alu_src(id_alu_src),
        .id_branch(id_branch), .id_jump(id_jump), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct(id_funct),
        .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_2_reg(ex_mem_2_reg), .ex_mem_write(ex_mem_write),
        .ex_alu_src(ex_alu_src), .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_pc(ex_pc),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct(ex_funct)
`ifdef ID_EX_PERF_CNT_EN
        , .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
`endif
    );

    // 10 ns core clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ctrl(input logic v, input logic [1:0] op, input logic rw, input logic mr,
                            input logic m2r, input logic mw, input logic as, input logic br,
                            input logic jp);
        id_valid = v; id_alu_op = op; id_reg_write = rw; id_mem_read = mr;
        id_mem_2_reg = m2r; id_mem_write = mw; id_alu_src = as; id_branch = br; id_jump = jp;
    endtask

    task automatic set_data(input logic [63:0] pc, input logic [63:0] r1d, input logic [63:0] r2d,
                            input logic [63:0] imm, input logic [4:0] r1, input logic [4:0] r2,
                            input logic [4:0] rd, input logic [3:0] fn);
        id_pc = pc; id_rs1_data = r1d; id_rs2_data = r2d; id_imm = imm;
        id_rs1 = r1; id_rs2 = r2; id_rd = rd; id_funct = fn;
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"},  {63'd0, ex_valid},     64'd0);
        check({tag, "_ctrl"},   {55'd0, ex_alu_op, ex_reg_write, ex_mem_read, ex_mem_2_reg,
                                 ex_mem_write, ex_alu_src, ex_branch, ex_jump}, 64'd0);
        check({tag, "_pc"},     ex_pc,       64'd0);
        check({tag, "_rs1d"},   ex_rs1_data, 64'd0);
        check({tag, "_rs2d"},   ex_rs2_data, 64'd0);
        check({tag, "_imm"},    ex_imm,      64'd0);
        check({tag, "_regs"},   {49'd0, ex_rs1, ex_rs2, ex_rd}, 64'd0);
        check({tag, "_funct"},  {60'd0, ex_funct}, 64'd0);
    endtask

    initial begin
        arst_n = 1'b0; en = 1'b0; flush = 1'b0;
        set_ctrl(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        set_data(64'd0, 64'd0, 64'd0, 64'd0, 5'd0, 5'd0, 5'd0, 4'd0);
        #2;
        check_all_zero("reset");
        edge_sample();
        check_all_zero("reset_held");

        // R-type load, then asynchronous reset between edges
        @(negedge clk);
        arst_n = 1'b1; en = 1'b1;
        set_ctrl(1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        set_data(64'h100, 64'h11, 64'h22, 64'd0, 5'd1, 5'd2, 5'd5, 4'b1000);
        edge_sample();
        check("rtype_valid", {63'd0, ex_valid}, 64'd1);
        check("rtype_aluop", {62'd0, ex_alu_op}, 64'd2);
        check("rtype_rw", {63'd0, ex_reg_write}, 64'd1);
        check("rtype_rd", {59'd0, ex_rd}, 64'd5);
        check("rtype_funct", {60'd0, ex_funct}, 64'h8);
        #2;
        arst_n = 1'b0;
        #1;
        check_all_zero("midreset");

        // Load: ld x3, 8(x2)
        @(negedge clk);
        arst_n = 1'b1;
        set_ctrl(1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        set_data(64'h104, 64'h1000, 64'h77, 64'd8, 5'd2, 5'd9, 5'd3, 4'b0011);
        edge_sample();
        check("ld_valid", {63'd0, ex_valid}, 64'd1);
        check("ld_ctrl", {55'd0, ex_alu_op, ex_reg_write, ex_mem_read, ex_mem_2_reg,
                          ex_mem_write, ex_alu_src, ex_branch, ex_jump}, 64'b0_0111_0100);
        check("ld_pc", ex_pc, 64'h104);
        check("ld_rs1d", ex_rs1_data, 64'h1000);
        check("ld_rs2d", ex_rs2_data, 64'h77);
        check("ld_imm", ex_imm, 64'd8);
        check("ld_regs", {49'd0, ex_rs1, ex_rs2, ex_rd}, {49'd0, 5'd2, 5'd9, 5'd3});
        check("ld_funct", {60'd0, ex_funct}, 64'h3);

        // Stall for three edges while decode inputs keep changing
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            en = 1'b0;
            set_ctrl(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
            set_data(64'h500 + 64'(i), 64'hAA, 64'hBB, 64'h40, 5'd7, 5'd8, 5'd9, 4'hF);
            edge_sample();
            check("stall_pc", ex_pc, 64'h104);
            check("stall_imm", ex_imm, 64'd8);
            check("stall_rd", {59'd0, ex_rd}, 64'd3);
            check("stall_ctrl", {54'd0, ex_valid, ex_alu_op, ex_reg_write, ex_mem_read,
                                 ex_mem_2_reg, ex_mem_write, ex_alu_src, ex_branch, ex_jump},
                  64'b10_0111_0100);
        end
`ifdef ID_EX_PERF_CNT_EN
        check("stall_cnt", {32'd0, stall_cnt}, 64'd3);
        check("bubble_cnt0", {32'd0, bubble_cnt}, 64'd0);
`endif

        // Store into EX: sd x7, 16(x2)
        @(negedge clk);
        en = 1'b1;
        set_ctrl(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        set_data(64'h108, 64'h2000, 64'hDEAD_BEEF_CAFE_F00D, 64'd16, 5'd2, 5'd7, 5'd0, 4'b0011);
        edge_sample();
        check("st_valid", {63'd0, ex_valid}, 64'd1);
        check("st_mw", {63'd0, ex_mem_write}, 64'd1);
        check("st_rs2d", ex_rs2_data, 64'hDEAD_BEEF_CAFE_F00D);

        // Flush while stalled: bubble, data retained
        @(negedge clk);
        flush = 1'b1; en = 1'b0;
        set_data(64'h300, 64'h1, 64'h2, 64'h3, 5'd4, 5'd5, 5'd6, 4'h1);
        edge_sample();
        check("fl_valid", {63'd0, ex_valid}, 64'd0);
        check("fl_ctrl", {55'd0, ex_alu_op, ex_reg_write, ex_mem_read, ex_mem_2_reg,
                          ex_mem_write, ex_alu_src, ex_branch, ex_jump}, 64'd0);
        check("fl_rs2d", ex_rs2_data, 64'hDEAD_BEEF_CAFE_F00D);
        check("fl_pc", ex_pc, 64'h108);
`ifdef ID_EX_PERF_CNT_EN
        check("fl_bubble_cnt", {32'd0, bubble_cnt}, 64'd1);
        check("fl_stall_cnt", {32'd0, stall_cnt}, 64'd3);
`endif

        // Flush overrides enable; data still retained
        @(negedge clk);
        flush = 1'b1; en = 1'b1;
        set_ctrl(1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        set_data(64'h200, 64'h5, 64'h6, 64'h7, 5'd10, 5'd11, 5'd12, 4'h2);
        edge_sample();
        check("flen_valid", {63'd0, ex_valid}, 64'd0);
        check("flen_rw", {63'd0, ex_reg_write}, 64'd0);
        check("flen_aluop", {62'd0, ex_alu_op}, 64'd0);
        check("flen_pc", ex_pc, 64'h108);
        check("flen_rd", {59'd0, ex_rd}, 64'd0);

        // Invalid decode: control bubbles, data loads
        @(negedge clk);
        flush = 1'b0; en = 1'b1;
        set_ctrl(1'b0, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        set_data(64'h40, 64'h9, 64'hA, 64'hB, 5'd13, 5'd14, 5'd15, 4'h5);
        edge_sample();
        check("inv_rw", {63'd0, ex_reg_write}, 64'd0);
        check("inv_valid", {63'd0, ex_valid}, 64'd0);
        check("inv_ctrl", {55'd0, ex_alu_op, ex_reg_write, ex_mem_read, ex_mem_2_reg,
                           ex_mem_write, ex_alu_src, ex_branch, ex_jump}, 64'd0);
        check("inv_pc", ex_pc, 64'h40);
        check("inv_rd", {59'd0, ex_rd}, 64'd15);
`ifdef ID_EX_PERF_CNT_EN
        check("inv_bubble_cnt", {32'd0, bubble_cnt}, 64'd3);
`endif

        // Branch then jump pass through
        @(negedge clk);
        set_ctrl(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        set_data(64'h44, 64'h1, 64'h1, 64'hFFFF_FFFF_FFFF_FFF0, 5'd1, 5'd1, 5'd0, 4'h0);
        edge_sample();
        check("br_ctrl", {54'd0, ex_valid, ex_alu_op, ex_reg_write, ex_mem_read, ex_mem_2_reg,
                          ex_mem_write, ex_alu_src, ex_branch, ex_jump}, 64'b10_1000_0010);
        check("br_imm", ex_imm, 64'hFFFF_FFFF_FFFF_FFF0);
        @(negedge clk);
        set_ctrl(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        set_data(64'h48, 64'h0, 64'h0, 64'h20, 5'd0, 5'd0, 5'd1, 4'h0);
        edge_sample();
        check("jal_ctrl", {54'd0, ex_valid, ex_alu_op, ex_reg_write, ex_mem_read, ex_mem_2_reg,
                           ex_mem_write, ex_alu_src, ex_branch, ex_jump}, 64'b10_0100_0001);
        check("jal_pc", ex_pc, 64'h48);

`ifdef ID_EX_PERF_CNT_EN
        // Saturation of the bubble counter
        @(negedge clk);
        force dut.bubble_cnt_r = 32'hFFFF_FFFE;
        #1;
        release dut.bubble_cnt_r;
        flush = 1'b1;
        for (int i = 0; i < 3; i++) edge_sample();
        check("sat_bubble_cnt", {32'd0, bubble_cnt}, 64'hFFFF_FFFF);
        @(negedge clk);
        flush = 1'b0;
`endif

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- ID/EX pipeline register of the pipelined RISC-V core.
- Sits directly downstream of the decode-stage control unit: captures its control bundle (alu_op, reg_write, mem_read, mem_2_reg, mem_write, alu_src, branch, jump) plus decode-stage operands, and presents them to EX one cycle later.
- Supports stall (hold) and flush (bubble insertion) driven by the hazard/branch logic.

Parameters:
- DATA_W, 64, width of register-file operands, immediate and PC
- REG_ADDR_W, 5, register index width
- FUNCT_W, 4, packed {instr[30], funct3} field width forwarded to ALU control

Ports:
- clk  in  1  core clock, rising-edge
- arst_n  in  1  asynchronous active-low reset
- en  in  1  1 = load new stage contents; 0 = hold (stall)
- flush  in  1  1 = insert bubble at next edge
- id_valid  in  1  decode stage holds a real instruction
- id_alu_op, id_reg_write, id_mem_read, id_mem_2_reg, id_mem_write, id_alu_src, id_branch, id_jump  in  2/1/1/1/1/1/1/1  control bundle from control unit
- id_pc  in  DATA_W  instruction PC
- id_rs1_data, id_rs2_data  in  DATA_W  register-file read data
- id_imm  in  DATA_W  sign-extended immediate
- id_rs1, id_rs2, id_rd  in  REG_ADDR_W  register indices (for forwarding/hazard)
- id_funct  in  FUNCT_W  ALU-control function bits
- ex_valid  out  1  EX holds a real instruction
- ex_alu_op ... ex_jump  out  same widths  registered control bundle
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct  out  same widths  registered data

Behaviour:
- Reset (arst_n low, asynchronous, any time incl. mid-stall): every output is 0, including ex_valid and ex_alu_op (2'b00). Deassertion takes effect at the next rising edge.
- Latency: exactly 1 cycle. Inputs sampled at edge N appear at the outputs after edge N.
- Priority per edge: reset > flush > en > hold.
- flush=1, regardless of en:
  - ex_valid and all control outputs become 0 (bubble: no reg write, no memory access, no branch/jump, alu_op=00).
  - Data outputs keep their previous values.
- flush=0, en=1: all outputs load from id_*.
  - If id_valid=0, control outputs load as 0 (bubble) and data loads normally.
  - An invalid instruction can never write state.
- flush=0, en=0: all outputs hold; back-to-back stalls hold indefinitely.
- Invariant: ex_valid=0 implies every control output is 0.
- No combinational path from any input to any output.

Optional Feature:
- Macro ID_EX_PERF_CNT_EN.
- Defined:
  - Adds outputs bubble_cnt (32) and stall_cnt (32), both reset to 0.
  - bubble_cnt +1 on each edge where a bubble is loaded (flush=1, or en=1 with id_valid=0).
  - stall_cnt +1 on each edge with flush=0, en=0.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - ALU_OP constants (ADD 00, SUB 01, R_TYPE 10)
  - CTRL_W = 9 and the bit positions of the packed control bundle
  - the opcode constants shared with the control unit
- One sub-module, pipe_reg_en: parameterised-width flop with async active-low reset, enable, and synchronous clear-to-zero.
- The block instantiates pipe_reg_en twice:
  - control+valid: clear = flush | (en & ~id_valid)
  - data: clear tied 0

Test Plan:
- Reset mid-operation: load R-type (alu_op=10, reg_write=1, rd=5), assert arst_n=0 between edges → all outputs 0 immediately, before the next clock edge.
- Normal flow: en=1, id_valid=1, load (mem_read=1, mem_2_reg=1, alu_src=1, imm=8, rd=3) → after one edge ex_* match exactly and ex_valid=1.
- Stall: hold en=0 for 3 cycles while id_* changes → ex_* unchanged. With ID_EX_PERF_CNT_EN, stall_cnt=3.
- Flush vs stall: flush=1, en=0 with a store in EX → ex_valid=0 and ex_mem_write=0, ex_rs2_data unchanged. With ID_EX_PERF_CNT_EN, bubble_cnt +1.
- Invalid decode: en=1, id_valid=0, id_reg_write=1, id_pc=0x40 → ex_reg_write=0, ex_valid=0, ex_pc=0x40.
- Counter saturation (ID_EX_PERF_CNT_EN): force bubble_cnt to 32'hFFFF_FFFE, apply 3 flushes → reads 32'hFFFF_FFFF.
